// File: rtl/dds_spi_pkg.sv
// Shared types and frame geometry for the DDS serial-port responder.
package dds_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StUpdate
  } state_e;

  localparam int unsigned INSTR_BITS    = 8;
  localparam int unsigned DATA_BITS     = 32;
  localparam int unsigned FRAME_BITS    = 40;
  localparam int unsigned READ_FLAG_BIT = 7;

endpackage

// File: rtl/dds_serial_port_if.sv
// Register-access handshake between the controller (master) and the DDS port (slave).
interface dds_serial_port_if;
  import dds_spi_pkg::*;

  logic                  wr_start;
  logic [INSTR_BITS-1:0] wr_addr;
  logic [DATA_BITS-1:0]  wr_din;
  logic                  wr_done;
  logic [DATA_BITS-1:0]  wr_dout;
  logic                  busy;

  modport master (
    output wr_start, wr_addr, wr_din,
    input  wr_done, wr_dout, busy
  );

  modport slave (
    input  wr_start, wr_addr, wr_din,
    output wr_done, wr_dout, busy
  );

endinterface

// File: rtl/dds_sclk_div.sv
// SCLK phase counter: fall_tick at each low-phase start, rise_tick at each high-phase start.
module dds_sclk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int unsigned CntW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(2 * CLK_DIV - 1);
  localparam logic [CntW-1:0] CntRise = CntW'(CLK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fall_tick_o = en_i && (cnt_q == '0);
  assign rise_tick_o = en_i && (cnt_q == CntRise);

endmodule

// File: rtl/dds_serial_port.sv
// Turns one handshake request into a 40-bit DDS serial frame, plus IO_UPDATE after writes.
module dds_serial_port
  import dds_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned UPD_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  dds_serial_port_if.slave  bus,
  output logic              SCLK,
  output logic              CSB,
  output logic              SDIO,
  output logic              SDIO_OE,
  input  logic              SDO,
  output logic              IO_UPDATE
);

  localparam logic [15:0] SetupLast = 16'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [15:0] HoldLast  = 16'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
  localparam logic [15:0] UpdLast   = 16'((UPD_WIDTH > 0) ? UPD_WIDTH - 1 : 0);

  state_e                state_q, state_d;
  logic                  start_q;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0]  rdata_q, rdata_d;
  logic [DATA_BITS-1:0]  dout_q, dout_d;
  logic [5:0]            bitcnt_q, bitcnt_d;
  logic [15:0]           tmr_q, tmr_d;
  logic                  rd_q, rd_d, last_q, last_d;
  logic                  sclk_q, sclk_d, csb_q, csb_d, sdio_q, sdio_d;
  logic                  oe_q, oe_d, upd_q, upd_d, done_q, done_d, busy_q, busy_d;
  logic                  fall_tick, rise_tick, hold_end;

  dds_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (state_q == StShift),
    .fall_tick_o (fall_tick),
    .rise_tick_o (rise_tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rdata_d  = rdata_q;
    dout_d   = dout_q;
    bitcnt_d = bitcnt_q;
    tmr_d    = tmr_q + 16'd1;
    rd_d     = rd_q;
    last_d   = last_q;
    sclk_d   = sclk_q;
    csb_d    = csb_q;
    sdio_d   = sdio_q;
    oe_d     = oe_q;
    upd_d    = upd_q;
    done_d   = done_q;
    busy_d   = busy_q;
    hold_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmr_d = '0;
        if (bus.wr_start && !start_q) begin
          shreg_d  = {bus.wr_addr, bus.wr_din};
          rd_d     = bus.wr_addr[READ_FLAG_BIT];
          bitcnt_d = 6'(FRAME_BITS - 1);
          last_d   = 1'b0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          csb_d    = 1'b0;
          sdio_d   = bus.wr_addr[INSTR_BITS-1];
          state_d  = (CS_SETUP == 0) ? StShift : StSetup;
        end
      end
      StSetup: begin
        if (tmr_q == SetupLast) begin
          tmr_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        tmr_d = '0;
        if (fall_tick) begin
          sclk_d = 1'b0;
          if (last_q) begin
            oe_d = 1'b1;
            if (CS_HOLD == 0) begin
              hold_end = 1'b1;
            end else begin
              state_d = StHold;
            end
          end else begin
            sdio_d = shreg_q[FRAME_BITS-1];
            // Release SDIO to the DDS for the whole data phase of a read.
            if (rd_q && (bitcnt_q == 6'(DATA_BITS - 1))) begin
              oe_d = 1'b0;
            end
          end
        end
        if (rise_tick) begin
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          if (bitcnt_q < 6'(DATA_BITS)) begin
            rdata_d = {rdata_q[DATA_BITS-2:0], SDO};
          end
          if (bitcnt_q == '0) begin
            last_d = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q - 6'd1;
          end
        end
      end
      StHold: begin
        if (tmr_q == HoldLast) begin
          hold_end = 1'b1;
        end
      end
      StUpdate: begin
        if (tmr_q == UpdLast) begin
          upd_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (hold_end) begin
      csb_d = 1'b1;
      tmr_d = '0;
      if (rd_q) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dout_d  = rdata_q;
        state_d = StIdle;
      end else begin
        upd_d   = 1'b1;
        state_d = StUpdate;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      shreg_q  <= '0;
      rdata_q  <= '0;
      dout_q   <= '0;
      bitcnt_q <= '0;
      tmr_q    <= '0;
      rd_q     <= 1'b0;
      last_q   <= 1'b0;
      sclk_q   <= 1'b0;
      csb_q    <= 1'b1;
      sdio_q   <= 1'b0;
      oe_q     <= 1'b1;
      upd_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.wr_start;
      shreg_q  <= shreg_d;
      rdata_q  <= rdata_d;
      dout_q   <= dout_d;
      bitcnt_q <= bitcnt_d;
      tmr_q    <= tmr_d;
      rd_q     <= rd_d;
      last_q   <= last_d;
      sclk_q   <= sclk_d;
      csb_q    <= csb_d;
      sdio_q   <= sdio_d;
      oe_q     <= oe_d;
      upd_q    <= upd_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign SCLK        = sclk_q;
  assign CSB         = csb_q;
  assign SDIO        = sdio_q;
  assign SDIO_OE     = oe_q;
  assign IO_UPDATE   = upd_q;
  assign bus.wr_done = done_q;
  assign bus.wr_dout = dout_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dds_serial_port.sv
// Bench for dds_serial_port: DDS pin model, vector table, random requests and corner sequences.
module tb_dds_serial_port;

  localparam int ClkDiv = 2, CsSetup = 2, CsHold = 2, UpdWidth = 4;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] sdo;
    bit          churn;
    int          lat;
    int          upd;
    int          oelow;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sclk0, csb0, sdio0, oe0, upd0;
  logic sdo0 = 1'b0;
  logic sclk1, csb1, sdio1, oe1, upd1;
  logic sdo1 = 1'b0;

  dds_serial_port_if bus0 ();
  dds_serial_port_if bus1 ();

  dds_serial_port dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0),
    .SCLK      (sclk0),
    .CSB       (csb0),
    .SDIO      (sdio0),
    .SDIO_OE   (oe0),
    .SDO       (sdo0),
    .IO_UPDATE (upd0)
  );

  dds_serial_port #(
    .CLK_DIV   (1),
    .CS_SETUP  (0),
    .CS_HOLD   (0),
    .UPD_WIDTH (4)
  ) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .SCLK      (sclk1),
    .CSB       (csb1),
    .SDIO      (sdio1),
    .SDIO_OE   (oe1),
    .SDO       (sdo1),
    .IO_UPDATE (upd1)
  );

  int tests = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // DDS chip model for the default-parameter instance.
  logic        sclk0_p = 1'b0, csb0_p = 1'b1;
  int          idx0 = 0, rises0 = 0, upd_cyc0 = 0, oelow0 = 0, falls0 = 0, oe_bad0 = 0;
  int          gate_bad = 0;
  logic [39:0] frame0 = '0;
  logic [7:0]  instr0 = '0;
  logic [31:0] rd_word = '0;

  always @(negedge clk) begin
    logic [31:0] sh;
    if (!csb0 && csb0_p) begin
      idx0 = 0;
      falls0++;
    end
    if (sclk0 && !sclk0_p) begin
      frame0 = {frame0[38:0], sdio0};
      if (oe0 !== !(idx0 >= 8 && instr0[7])) oe_bad0++;
      idx0++;
      rises0++;
      if (idx0 == 8) instr0 = frame0[7:0];
    end
    if (!sclk0 && sclk0_p && idx0 >= 8 && idx0 < 40) begin
      sh   = rd_word << (idx0 - 8);
      sdo0 = sh[31];
    end
    if (!oe0) oelow0++;
    if (upd0) upd_cyc0++;
    if ((sclk0 && csb0) || (sclk1 && csb1)) gate_bad++;
    sclk0_p = sclk0;
    csb0_p  = csb0;
  end

  // Minimal capture for the fast instance.
  logic        sclk1_p = 1'b0;
  int          rises1 = 0, tog1 = 0;
  logic [39:0] frame1 = '0;

  always @(negedge clk) begin
    if (sclk1 && !sclk1_p) begin
      frame1 = {frame1[38:0], sdio1};
      rises1++;
    end
    if (sclk1 != sclk1_p) tog1++;
    sclk1_p = sclk1;
  end

  logic [31:0] model_dout = '0;

  function automatic vec_t mk(input logic [7:0] a, input logic [31:0] d, input logic [31:0] s,
                              input bit churn);
    vec_t v;
    v.addr  = a;
    v.din   = d;
    v.sdo   = s;
    v.churn = churn;
    v.lat   = 1 + CsSetup + 80 * ClkDiv + CsHold + (a[7] ? 0 : UpdWidth);
    v.upd   = a[7] ? 0 : UpdWidth;
    v.oelow = a[7] ? 32 * 2 * ClkDiv : 0;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input bit hold, input int poke);
    int r0, u0, o0, f0, b0, lat;
    r0 = rises0; u0 = upd_cyc0; o0 = oelow0; f0 = falls0; b0 = oe_bad0;
    rd_word = v.sdo;
    @(negedge clk);
    bus0.wr_addr  = v.addr;
    bus0.wr_din   = v.din;
    bus0.wr_start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus0.wr_start = 1'b0;
    check("accept_done_clr", bus0.wr_done, 0);
    check("accept_busy", bus0.busy, 1);
    lat = -1;
    for (int k = 1; k <= 2000 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (v.churn) begin
        bus0.wr_din  = $urandom;
        bus0.wr_addr = 8'($urandom);
      end
      if (k == poke) bus0.wr_start = 1'b1;
      if (k == poke + 1 && poke > 0) bus0.wr_start = 1'b0;
      if (bus0.wr_done) lat = k;
    end
    check("latency", 64'(lat), 64'(v.lat));
    if (v.addr[7]) begin
      check("instr_rd", frame0[39:32], v.addr);
      model_dout = v.sdo;
    end else begin
      check("frame_wr", frame0, {v.addr, v.din});
    end
    check("sclk_rises", 64'(rises0 - r0), 40);
    check("io_update_cycles", 64'(upd_cyc0 - u0), 64'(v.upd));
    check("oe_low_cycles", 64'(oelow0 - o0), 64'(v.oelow));
    check("oe_per_bit", 64'(oe_bad0 - b0), 0);
    check("frames", 64'(falls0 - f0), 1);
    check("busy_end", bus0.busy, 0);
    check("wr_dout", bus0.wr_dout, model_dout);
  endtask

  vec_t vecs[10];

  initial begin
    int f0, n, lat;
    bus0.wr_start = 1'b0; bus0.wr_addr = '0; bus0.wr_din = '0;
    bus1.wr_start = 1'b0; bus1.wr_addr = '0; bus1.wr_din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", sclk0, 0);
    check("rst_csb", csb0, 1);
    check("rst_sdio", sdio0, 0);
    check("rst_oe", oe0, 1);
    check("rst_upd", upd0, 0);
    check("rst_done", bus0.wr_done, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_dout", bus0.wr_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = mk(8'h02, 32'h1D3F_4100, 32'h0, 1'b0);
    vecs[1] = mk(8'h87, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    vecs[2] = mk(8'h0B, 32'hA5C3_0F96, 32'h0, 1'b1);
    vecs[3] = mk(8'h00, 32'hFFFF_FFFF, 32'h0, 1'b0);
    vecs[4] = mk(8'hFF, 32'h0, 32'h8000_0001, 1'b0);
    for (int i = 5; i < 10; i++) begin
      vecs[i] = mk(8'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 10; i++) do_txn(vecs[i], 1'b0, 0);

    // Held start never retriggers; an edge while busy is dropped.
    f0 = falls0;
    do_txn(mk(8'h04, 32'h0BAD_F00D, 32'h0, 1'b0), 1'b1, 0);
    repeat (20) @(posedge clk);
    #1;
    check("held_no_retrigger", 64'(falls0 - f0), 1);
    check("held_done_level", bus0.wr_done, 1);
    check("held_not_busy", bus0.busy, 0);
    @(negedge clk);
    bus0.wr_start = 1'b0;
    f0 = falls0;
    do_txn(mk(8'h91, 32'h0, 32'hCAFE_0123, 1'b0), 1'b0, 60);
    repeat (10) @(posedge clk);
    #1;
    check("busy_edge_dropped", 64'(falls0 - f0), 1);
    check("done_stays", bus0.wr_done, 1);

    // Reset in the middle of a write frame.
    @(negedge clk);
    bus0.wr_addr = 8'h05; bus0.wr_din = 32'h1111_2222; bus0.wr_start = 1'b1;
    @(posedge clk);
    #1;
    bus0.wr_start = 1'b0;
    n = 0;
    while (idx0 < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit20", 64'(idx0 >= 20), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_csb", csb0, 1);
    check("mid_rst_sclk", sclk0, 0);
    check("mid_rst_upd", upd0, 0);
    check("mid_rst_done", bus0.wr_done, 0);
    check("mid_rst_busy", bus0.busy, 0);
    check("mid_rst_dout", bus0.wr_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    model_dout = '0;
    do_txn(mk(8'h06, 32'h7654_3210, 32'h0, 1'b0), 1'b0, 0);

    // Fast divider instance.
    n = rises1;
    f0 = tog1;
    @(negedge clk);
    bus1.wr_addr = 8'h15; bus1.wr_din = 32'h3C3C_A5A5; bus1.wr_start = 1'b1;
    @(posedge clk);
    #1;
    bus1.wr_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 1000 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (bus1.wr_done) lat = k;
    end
    check("fast_latency", 64'(lat), 85);
    check("fast_rises", 64'(rises1 - n), 40);
    check("fast_toggles", 64'(tog1 - f0), 80);
    check("fast_frame", frame1, {8'h15, 32'h3C3C_A5A5});

    check("sclk_low_when_csb_high", 64'(gate_bad), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
